// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking and frame-synchronous load.
// Optional leading-zero suppression: define SSD_LZ_SUPPRESS_EN.
module ssd_scan_ctrl #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_done,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam int BLK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BK_LAST = CW'(BLK_LAST);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;
    localparam state_t ST_RST = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_disp;
    logic [15:0]   r_pend;
    logic          r_pend_valid;

    state_t        w_nxt_state;
    logic [1:0]    w_nxt_idx;
    logic [CW-1:0] w_nxt_cnt;
    logic [15:0]   w_disp_nxt;
    logic [3:0]    w_nib;
    logic          w_lz;
    logic [3:0]    w_an;
    logic          w_fd;

    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = CW'(r_cnt + 1'b1);
        if (r_state == ST_BLANK) begin
            if (r_cnt == BK_LAST) begin
                w_nxt_state = ST_DRIVE;
                w_nxt_cnt   = '0;
            end
        end else if (r_cnt == DW_LAST) begin
            w_nxt_idx   = r_idx + 2'd1;
            w_nxt_cnt   = '0;
            w_nxt_state = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        end
    end

    // Commit lands on the frame boundary, so the next cycle's outputs see the new value.
    assign w_disp_nxt = (frame_done && r_pend_valid) ? r_pend : r_disp;
    assign w_nib      = w_disp_nxt[{w_nxt_idx, 2'b00} +: 4];
    assign w_an       = ~(4'b0001 << w_nxt_idx);
    assign w_fd       = (w_nxt_state == ST_DRIVE) && (w_nxt_idx == 2'd3)
                        && (w_nxt_cnt == DW_LAST);

`ifdef SSD_LZ_SUPPRESS_EN
    always_comb begin
        w_lz = 1'b0;
        unique case (w_nxt_idx)
            2'd1:    w_lz = (w_disp_nxt[15:4] == 12'h000);
            2'd2:    w_lz = (w_disp_nxt[15:8] == 8'h00);
            2'd3:    w_lz = (w_disp_nxt[15:12] == 4'h0);
            default: w_lz = 1'b0;
        endcase
    end
`else
    assign w_lz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RST;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_disp       <= 16'h0000;
            r_pend       <= 16'h0000;
            r_pend_valid <= 1'b0;
            load_ack     <= 1'b0;
            frame_done   <= 1'b0;
            seg_n        <= 7'h7F;
            an_n         <= 4'hF;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_cnt        <= w_nxt_cnt;
            r_disp       <= w_disp_nxt;
            if (load) r_pend <= value_in;
            r_pend_valid <= load | (r_pend_valid & ~frame_done);
            load_ack     <= load;
            frame_done   <= w_fd;
            if (w_nxt_state == ST_DRIVE) begin
                seg_n <= hex2seg(w_nib);
                an_n  <= w_lz ? 4'hF : w_an;
            end else begin
                seg_n <= 7'h7F;
                an_n  <= 4'hF;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl (DWELL=4, BLANK=2) against a cycle-position model.
module tb_ssd_scan_ctrl;

    localparam int DW = 4;
    localparam int BK = 2;
    localparam int SLOT = DW + BK;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = 16'h0;
    logic        load = 1'b0;
    logic        load_ack;
    logic        frame_done;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;

    int tests = 0;
    int fails = 0;

    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pv;
    bit          m_ack;

    logic [6:0] MAP [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    ssd_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BK)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load),
        .load_ack(load_ack), .frame_done(frame_done), .seg_n(seg_n), .an_n(an_n)
    );

    always #5 clk = ~clk;

    // Expected {an_n, seg_n, frame_done, load_ack} for the current cycle t.
    function automatic logic [12:0] exp_out();
        int p = t % FRAME;
        int d = p / SLOT;
        int o = p % SLOT;
        logic [3:0] an = 4'hF;
        logic [6:0] sg = 7'h7F;
        logic [15:0] sh = m_disp >> (4 * d);
        logic [3:0] nib = sh[3:0];
        if (o >= BK) begin
            an = 4'hF ^ (4'b0001 << d);
            sg = MAP[nib];
`ifdef SSD_LZ_SUPPRESS_EN
            if (d > 0 && sh == 16'h0) an = 4'hF;
`endif
        end
        return {an, sg, (p == FRAME - 1), m_ack};
    endfunction

    task automatic step(input bit ld, input logic [15:0] v);
        load = ld;
        value_in = v;
        @(posedge clk);
        #1;
        if (t % FRAME == FRAME - 1 && m_pv) begin
            m_disp = m_pend;
            m_pv = 0;
        end
        if (ld) begin
            m_pend = v;
            m_pv = 1;
        end
        m_ack = ld;
        t++;
        load = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        load = 1'b1;
        value_in = 16'(  $urandom);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        load = 1'b0;
        t = 0;
        m_disp = 16'h0;
        m_pend = 16'h0;
        m_pv = 0;
        m_ack = 0;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        do_reset(3);
        got = {an_n, seg_n, frame_done, load_ack};
        tests++;
        if (got !== {4'hF, 7'h7F, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_vals got=%h exp=%h", got, {4'hF, 7'h7F, 2'b00});
        end
    endtask

    task automatic test_scan_timing();
        logic [12:0] got, exp;
        for (int c = 0; c < FRAME; c++) begin
            got = {an_n, seg_n, frame_done, load_ack};
            exp = exp_out();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL scan c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 1 || c == 2 || c == 5 || c == 6 || c == 22 || c == 23) begin
                tests++;
                if ((c == 1 || c == 6) && an_n !== 4'hF) begin
                    fails++;
                    $display("FAIL blank_an c=%0d got=%h exp=f", c, an_n);
                end else if ((c == 2 || c == 5) && {an_n, seg_n} !== {4'b1110, 7'h40}) begin
                    fails++;
                    $display("FAIL drive0 c=%0d got=%h/%h exp=e/40", c, an_n, seg_n);
                end else if ((c == 22 || c == 23) && frame_done !== (c == 23)) begin
                    fails++;
                    $display("FAIL frame_done c=%0d got=%b exp=%b", c, frame_done, c == 23);
                end
            end
            step(0, 16'h0);
        end
    endtask

    task automatic test_load_mid();
        logic [12:0] got, exp;
        logic [6:0] want [4] = '{7'h0E, 7'h24, 7'h08, 7'h79};
        for (int c = 0; c < 2 * FRAME; c++) begin
            got = {an_n, seg_n, frame_done, load_ack};
            exp = exp_out();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL load_mid c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 10) begin
                tests++;
                if (load_ack !== 1'b1) begin
                    fails++;
                    $display("FAIL load_ack got=%b exp=1", load_ack);
                end
            end
            if (c >= FRAME && (c % SLOT) == BK) begin
                tests++;
                if (seg_n !== want[(c % FRAME) / SLOT]) begin
                    fails++;
                    $display("FAIL new_digit c=%0d got=%h exp=%h", c, seg_n,
                             want[(c % FRAME) / SLOT]);
                end
            end
            step(c == 9, 16'h1A2F);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] got, exp;
        int acks = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            got = {an_n, seg_n, frame_done, load_ack};
            exp = exp_out();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL b2b c=%0d got=%h exp=%h", c, got, exp);
            end
            if (load_ack === 1'b1) acks++;
            if (c >= FRAME && an_n !== 4'hF) begin
                tests++;
                if (seg_n !== 7'h24) begin
                    fails++;
                    $display("FAIL last_wins c=%0d got=%h exp=24", c, seg_n);
                end
            end
            if (c == 3) step(1, 16'h1111);
            else if (c == 10) step(1, 16'h2222);
            else step(0, 16'h0);
        end
        tests++;
        if (acks != 2) begin
            fails++;
            $display("FAIL ack_count got=%0d exp=2", acks);
        end
    endtask

    task automatic test_commit_cycle();
        logic [12:0] got, exp;
        for (int c = 0; c < 3 * FRAME; c++) begin
            got = {an_n, seg_n, frame_done, load_ack};
            exp = exp_out();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL commit c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == FRAME - 1) begin
                tests++;
                if (frame_done !== 1'b1) begin
                    fails++;
                    $display("FAIL commit_fd got=%b exp=1", frame_done);
                end
            end
            if (c == FRAME + BK || c == 2 * FRAME + BK) begin
                tests++;
                if (seg_n !== ((c < 2 * FRAME) ? 7'h19 : 7'h30)) begin
                    fails++;
                    $display("FAIL commit_seq c=%0d got=%h exp=%h", c, seg_n,
                             (c < 2 * FRAME) ? 7'h19 : 7'h30);
                end
            end
            if (c == 5) step(1, 16'h4444);
            else if (c == FRAME - 1) step(1, 16'h3333);
            else step(0, 16'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] got, exp;
        for (int c = 0; c < 15; c++) step(c == 3, 16'h5678);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({an_n, seg_n, load_ack, frame_done} !== {4'hF, 7'h7F, 2'b00}) begin
            fails++;
            $display("FAIL rst_mid got=%h/%h exp=f/7f", an_n, seg_n);
        end
        rst = 1'b0;
        t = 0;
        m_disp = 16'h0;
        m_pv = 0;
        m_ack = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            got = {an_n, seg_n, frame_done, load_ack};
            exp = exp_out();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL rst_mid_scan c=%0d got=%h exp=%h", c, got, exp);
            end
            if (an_n !== 4'hF && seg_n !== 7'h40) begin
                tests++;
                fails++;
                $display("FAIL discard c=%0d got=%h exp=40", c, seg_n);
            end
            step(0, 16'h0);
        end
    endtask

`ifdef SSD_LZ_SUPPRESS_EN
    task automatic test_lz();
        logic [12:0] got, exp;
        step(1, 16'h0050);
        while (t % FRAME != 0) step(0, 16'h0);
        for (int c = 0; c < FRAME; c++) begin
            got = {an_n, seg_n, frame_done, load_ack};
            exp = exp_out();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL lz c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c >= 2 * SLOT) begin
                tests++;
                if (an_n !== 4'hF) begin
                    fails++;
                    $display("FAIL lz_off c=%0d got=%h exp=f", c, an_n);
                end
            end
            step(0, 16'h0);
        end
    endtask
`endif

    task automatic test_random();
        logic [12:0] got, exp;
        logic [15:0] v;
        for (int c = 0; c < 1500; c++) begin
            got = {an_n, seg_n, frame_done, load_ack};
            exp = exp_out();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL rand c=%0d got=%h exp=%h", c, got, exp);
            end
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1 + $urandom_range(0, 2));
            end else begin
                v = 16'($urandom);
                if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
                step($urandom_range(0, 9) == 0, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_load_mid();
        test_back_to_back();
        test_commit_cycle();
        test_reset_mid();
`ifdef SSD_LZ_SUPPRESS_EN
        test_lz();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
